uart_rx: RTL

- Serial receiver matching the project's UART transmitter: 8N1 framing, LSB first, idle-high line, 50 MHz clk, BAUD_DIV clocks per bit (2604 = 19200 baud).
- Sits between the external RX pin and the command/packet layer.
- Presents each received byte with a sticky rdy flag that the consumer clears.
- Also flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, rx state encoding and a 2-of-3 vote helper.
package uart_pkg;

  localparam int unsigned UART_BAUD_DIV_50M_19200 = 2604;
  localparam int unsigned UART_FRAME_BITS         = 10;
  localparam int unsigned UART_DATA_W             = 8;
  localparam int unsigned UART_SHIFT_W            = 9;
  localparam int unsigned UART_BAUD_CNT_W         = 12;
  localparam int unsigned UART_BIT_CNT_W          = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RECEIVE = 1'b1
  } uart_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus a third flop for falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic line,
  output logic fall_c
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Idle-high line: reset to 1 so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign line   = sync2;
  assign fall_c = sync3 & ~sync2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with sticky rdy / framing / overrun flags.
// Optional UART_RX_MAJORITY_EN: each bit is the 2-of-3 vote of the last three samples.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV_50M_19200,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RX,
  input  logic                   clr_rdy,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rdy,
  output logic                   frm_err,
  output logic                   ovr_err
);

  localparam logic [UART_BAUD_CNT_W-1:0] HALF_INIT = UART_BAUD_CNT_W'(HALF_DIV);
  localparam logic [UART_BAUD_CNT_W-1:0] HALF_LOAD = UART_BAUD_CNT_W'(HALF_DIV - 1);
  localparam logic [UART_BAUD_CNT_W-1:0] BAUD_LOAD = UART_BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [UART_BIT_CNT_W-1:0]  STOP_IDX  = UART_BIT_CNT_W'(UART_FRAME_BITS - 1);

  uart_rx_state_e              state, state_nxt;
  logic [UART_BAUD_CNT_W-1:0]  baud_cnt, baud_nxt;
  logic [UART_BIT_CNT_W-1:0]   bit_cnt, bit_nxt;
  logic [UART_SHIFT_W-1:0]     shreg, shreg_nxt;
  logic [UART_DATA_W-1:0]      data_nxt;
  logic                        rdy_nxt;
  logic                        frm_nxt;
  logic                        ovr_nxt;

  logic                        line;
  logic                        fall_c;
  logic                        strobe_c;
  logic                        sample_c;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx     (RX),
    .line   (line),
    .fall_c (fall_c)
  );

  assign strobe_c = (state == RECEIVE) && (baud_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote, vote_nxt;

  // Capture the line two and one clocks before the strobe for the vote.
  always_comb begin
    vote_nxt = vote;
    if (state == RECEIVE && baud_cnt == UART_BAUD_CNT_W'(2)) vote_nxt[0] = line;
    if (state == RECEIVE && baud_cnt == UART_BAUD_CNT_W'(1)) vote_nxt[1] = line;
  end

  always_ff @(posedge clk) begin
    if (rst) vote <= 2'b11;
    else     vote <= vote_nxt;
  end

  assign sample_c = maj3(vote[0], vote[1], line);
`else
  assign sample_c = line;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= HALF_INIT;
      bit_cnt  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
      ovr_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      rx_data  <= data_nxt;
      rdy      <= rdy_nxt;
      frm_err  <= frm_nxt;
      ovr_err  <= ovr_nxt;
    end
  end

  // Next-state, counters and flags; a completing byte overrides a same-cycle clear.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    data_nxt  = rx_data;
    rdy_nxt   = rdy;
    frm_nxt   = frm_err;
    ovr_nxt   = ovr_err;

    if (clr_rdy) begin
      rdy_nxt = 1'b0;
      frm_nxt = 1'b0;
      ovr_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (fall_c) begin
          state_nxt = RECEIVE;
          baud_nxt  = HALF_LOAD;
          bit_nxt   = '0;
        end
      end
      RECEIVE: begin
        if (strobe_c) begin
          baud_nxt = BAUD_LOAD;
          if (bit_cnt == '0) begin
            if (sample_c) state_nxt = IDLE;
            else          bit_nxt   = UART_BIT_CNT_W'(1);
          end else if (bit_cnt == STOP_IDX) begin
            data_nxt  = shreg[UART_SHIFT_W-1:1];
            rdy_nxt   = 1'b1;
            frm_nxt   = ~sample_c;
            ovr_nxt   = clr_rdy ? 1'b0 : (ovr_err | rdy);
            state_nxt = IDLE;
          end else begin
            shreg_nxt = {sample_c, shreg[UART_SHIFT_W-1:1]};
            bit_nxt   = bit_cnt + UART_BIT_CNT_W'(1);
          end
        end else begin
          baud_nxt = baud_cnt - UART_BAUD_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
